key_cmd_filter: RTL

Keyboard conditioning stage directly upstream of the ball motion block. Each frame it samples the raw two-slot USB HID keycode word, selects one direction key (A/W/S/D), debounces it over a configurable number of frames, and presents a clean 16-bit `keycode` to the motion stage. It also emits a one-frame `key_event` pulse on every accepted press (and on auto-repeat, if compiled in), plus a running event count for the move-sequence logic.

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_slot_select.sv | 32 +++
 rtl/key_cmd_filter.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared HID direction key codes and key filter FSM state type
//
// Purpose: constants and types shared by the key filter and the motion stage.
//   KEY_A / KEY_W / KEY_S / KEY_D : HID usage codes of the four direction keys
//   KEY_NONE                      : empty HID slot
//   key_state_t                   : filter FSM states
//   is_dir_key()                  : true when a slot holds one of the direction keys
package key_pkg;

  localparam logic [7:0] KEY_A    = 8'h04;
  localparam logic [7:0] KEY_W    = 8'h1A;
  localparam logic [7:0] KEY_S    = 8'h16;
  localparam logic [7:0] KEY_D    = 8'h07;
  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    HELD      = 2'd2,
    RELEASING = 2'd3
  } key_state_t;

  function automatic logic is_dir_key(input logic [7:0] k);
    return (k == KEY_A) || (k == KEY_W) || (k == KEY_S) || (k == KEY_D);
  endfunction

endpackage

// File: rtl/key_slot_select.sv
// rtl/key_slot_select.sv - picks one direction key out of the two-slot HID word
//
// Purpose: combinational slot decode; slot0 has priority over slot1.
// Ports:
//   keycode_raw [15:0] in  : raw HID keys, slot0 = [7:0], slot1 = [15:8]
//   sel         [7:0]  out : selected direction key, KEY_NONE when neither slot has one
//   sel_valid          out : sel holds a direction key
module key_slot_select
  import key_pkg::*;
(
  input  logic [15:0] keycode_raw,
  output logic [7:0]  sel,
  output logic        sel_valid
);

  logic [7:0] slot0;
  logic [7:0] slot1;

  assign slot0 = keycode_raw[7:0];
  assign slot1 = keycode_raw[15:8];

  always_comb begin
    sel = KEY_NONE;
    if (is_dir_key(slot0)) begin
      sel = slot0;
    end else if (is_dir_key(slot1)) begin
      sel = slot1;
    end
    sel_valid = (sel != KEY_NONE);
  end

endmodule

// File: rtl/key_cmd_filter.sv
// rtl/key_cmd_filter.sv - per-frame debounce of one direction key for the motion stage
//
// Purpose: selects a direction key from the raw HID word, requires STABLE_FRAMES
// consecutive samples to accept a press or a release, and reports the clean key,
// a one-frame event pulse per accepted press (and per auto-repeat when built with
// KEY_CMD_FILTER_REPEAT_EN) and a modulo-256 event count. All outputs registered.
// Ports:
//   frame_clk          in  : frame clock, state updates on rising edge
//   Reset              in  : asynchronous, active-high reset
//   keycode_raw [15:0] in  : raw HID keys, slot0 = [7:0], slot1 = [15:8]
//   keycode     [15:0] out : accepted key zero-extended, 0 when none held
//   key_event          out : one-frame pulse per accepted press or repeat
//   event_count [7:0]  out : number of key_event pulses modulo 256
//   held               out : FSM in HELD or RELEASING
// Build option: KEY_CMD_FILTER_REPEAT_EN adds the auto-repeat counter.
module key_cmd_filter
  import key_pkg::*;
#(
  parameter int STABLE_FRAMES = 3,
  parameter int REPEAT_FRAMES = 15
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [15:0] keycode_raw,
  output logic [15:0] keycode,
  output logic        key_event,
  output logic [7:0]  event_count,
  output logic        held
);

  localparam logic [4:0] STABLE_W  = 5'(STABLE_FRAMES);
  localparam bit         ONE_FRAME = (STABLE_FRAMES == 1);

  if (STABLE_FRAMES < 1 || STABLE_FRAMES > 15) begin : g_bad_stable
    $error("key_cmd_filter: STABLE_FRAMES must be within 1..15");
  end
  if (REPEAT_FRAMES < 1 || REPEAT_FRAMES > 255) begin : g_bad_repeat
    $error("key_cmd_filter: REPEAT_FRAMES must be within 1..255");
  end

  logic [7:0]  sel;
  logic        sel_valid;

  key_state_t  state_q, state_d;
  logic [7:0]  cand_q, cand_d;
  logic [7:0]  hold_key_q, hold_key_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] keycode_q, keycode_d;
  logic        key_event_q, key_event_d;
  logic [7:0]  event_count_q, event_count_d;
  logic        held_q, held_d;

  logic        press;
  logic        do_release;
  logic        cnt_reach;
  logic        repeat_fire;
  logic        event_now;

  key_slot_select u_slot_select (
    .keycode_raw (keycode_raw),
    .sel         (sel),
    .sel_valid   (sel_valid)
  );

  // State register
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      cand_q        <= KEY_NONE;
      hold_key_q    <= KEY_NONE;
      cnt_q         <= 4'd0;
      keycode_q     <= 16'h0000;
      key_event_q   <= 1'b0;
      event_count_q <= 8'd0;
      held_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      hold_key_q    <= hold_key_d;
      cnt_q         <= cnt_d;
      keycode_q     <= keycode_d;
      key_event_q   <= key_event_d;
      event_count_q <= event_count_d;
      held_q        <= held_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    hold_key_d = hold_key_q;
    cnt_d      = cnt_q;
    press      = 1'b0;
    do_release = 1'b0;
    // cnt counts matching samples so far; this sample would be number cnt+1
    cnt_reach  = ({1'b0, cnt_q} + 5'd1) >= STABLE_W;

    unique case (state_q)
      IDLE: begin
        if (sel_valid) begin
          cand_d = sel;
          cnt_d  = 4'd1;
          if (ONE_FRAME) begin
            hold_key_d = sel;
            press      = 1'b1;
            state_d    = HELD;
          end else begin
            state_d = ARMING;
          end
        end
      end
      ARMING: begin
        if (!sel_valid) begin
          state_d = IDLE;
        end else if (sel == cand_q) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_reach) begin
            hold_key_d = cand_q;
            press      = 1'b1;
            state_d    = HELD;
          end
        end else begin
          cand_d = sel;
          cnt_d  = 4'd1;
        end
      end
      HELD: begin
        if (sel != hold_key_q) begin
          cnt_d = 4'd1;
          // A single stable frame means the first mismatch is already the release
          if (ONE_FRAME) begin
            do_release = 1'b1;
          end else begin
            state_d = RELEASING;
          end
        end
      end
      RELEASING: begin
        if (sel == hold_key_q) begin
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_reach) begin
            do_release = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // The releasing sample doubles as the first arming sample of a new key
    if (do_release) begin
      if (sel_valid) begin
        cand_d  = sel;
        cnt_d   = 4'd1;
        state_d = ARMING;
      end else begin
        cnt_d   = 4'd0;
        state_d = IDLE;
      end
    end
  end

`ifdef KEY_CMD_FILTER_REPEAT_EN
  localparam logic [7:0] REPEAT_W = 8'(REPEAT_FRAMES);

  logic [7:0] rpt_q, rpt_d;

  // Counts only HELD->HELD edges, so it holds its value across a RELEASING glitch
  always_comb begin
    rpt_d       = rpt_q;
    repeat_fire = 1'b0;
    if (press) begin
      rpt_d = 8'd0;
    end else if (state_q == HELD && state_d == HELD) begin
      if (rpt_q + 8'd1 == REPEAT_W) begin
        rpt_d       = 8'd0;
        repeat_fire = 1'b1;
      end else begin
        rpt_d = rpt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      rpt_q <= 8'd0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`else
  always_comb begin
    repeat_fire = 1'b0;
  end
`endif

  // Output logic
  always_comb begin
    event_now = press | repeat_fire;
    keycode_d = keycode_q;
    if (press) begin
      keycode_d = {8'h00, hold_key_d};
    end else if (do_release) begin
      keycode_d = 16'h0000;
    end
    key_event_d   = event_now;
    event_count_d = event_count_q + {7'd0, event_now};
    held_d        = (state_d == HELD) || (state_d == RELEASING);
  end

  assign keycode     = keycode_q;
  assign key_event   = key_event_q;
  assign event_count = event_count_q;
  assign held        = held_q;

endmodule
